// File: rtl/rst_seq_pkg.sv
// Shared types and default sizing for the reset sequencer.
// The state encoding is fixed so debug tools can decode the raw state register.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2,
        ST_SOFT   = 2'd3
    } rst_seq_state_e;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int STRETCH_CYCLES_DEF = 1024;
    localparam int STAGE_GAP_DEF      = 16;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sys_if.sv
// Soft-reset handshake and staged reset outputs of the reset sequencer.
// The sequencer uses the slave modport; the consumer of the resets uses master.
interface rst_seq_sys_if;
    logic soft_rst_req_i;
    logic soft_rst_ack_o;
    logic rst_periph_n_o;
    logic rst_core_n_o;
    logic rst_done_o;
    logic rst_cause_soft_o;

    modport slave (
        input  soft_rst_req_i,
        output soft_rst_ack_o,
        output rst_periph_n_o,
        output rst_core_n_o,
        output rst_done_o,
        output rst_cause_soft_o
    );

    modport master (
        output soft_rst_req_i,
        input  soft_rst_ack_o,
        input  rst_periph_n_o,
        input  rst_core_n_o,
        input  rst_done_o,
        input  rst_cause_soft_o
    );
endinterface

// File: rtl/rst_seq_sys_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_async_n_i,
    output logic rst_sync_n_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_sys or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_sys.sv
// Reset sequencer: stretches a synchronized hard reset, releases peripherals then the
// core, and replays the sequence on a software reset request accepted in RUN.
module rst_seq_sys
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
    parameter int STAGE_GAP      = STAGE_GAP_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    rst_seq_sys_if.slave  bus
);

    localparam int CNT_W = $clog2(max_i(STRETCH_CYCLES, STAGE_GAP) + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    generate
        if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_param
            $error("rst_seq_sys: illegal parameters SYNC_STAGES=%0d STRETCH_CYCLES=%0d STAGE_GAP=%0d",
                   SYNC_STAGES, STRETCH_CYCLES, STAGE_GAP);
        end
    endgenerate

    logic           rst_sync_n;
    rst_seq_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           req_q;
    logic           soft_edge;
    logic           periph_n_q;
    logic           core_n_q;
    logic           done_q;
    logic           ack_q;
    logic           cause_soft_q;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_sys       (clk_sys),
        .rst_async_n_i (rst_sys_n),
        .rst_sync_n_o  (rst_sync_n)
    );

    assign soft_edge = bus.soft_rst_req_i & ~req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (rst_sync_n) begin
                    if (cnt_q == STRETCH_LAST) begin
                        state_d = ST_PERIPH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PERIPH: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (soft_edge) begin
                    state_d = ST_SOFT;
                    cnt_d   = '0;
                end
            end
            ST_SOFT: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM flops release straight off rst_sys_n; rst_sync_n is still low at that
    // moment so HOLD cannot advance on a marginal release edge.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            periph_n_q   <= 1'b0;
            core_n_q     <= 1'b0;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
            cause_soft_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= bus.soft_rst_req_i;
            periph_n_q   <= (state_d == ST_PERIPH) || (state_d == ST_RUN);
            core_n_q     <= (state_d == ST_RUN);
            done_q       <= (state_d == ST_RUN);
            ack_q        <= (state_d == ST_SOFT);
            cause_soft_q <= cause_soft_q | (state_d == ST_SOFT);
        end
    end

    assign bus.rst_periph_n_o   = periph_n_q;
    assign bus.rst_core_n_o     = core_n_q;
    assign bus.rst_done_o       = done_q;
    assign bus.soft_rst_ack_o   = ack_q;
    assign bus.rst_cause_soft_o = cause_soft_q;

endmodule

// File: doc/rst_seq_sys.md
RST_SEQ_SYS -- requirements
Module: rst_seq_sys

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: deassertion synchronizer depth; legal range >= 2.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 1024: reset hold after synchronized release; legal range >= 1.
REQ-003 SHALL have parameter STAGE_GAP, default 16: cycles between peripheral and core release; legal range >= 1.
REQ-004 SHALL have port clk_sys, input, 1: the single clock.
REQ-005 SHALL have port rst_sys_n, input, 1: reset, asynchronous, active-low (PLL locked AND board reset).
REQ-006 SHALL have port soft_rst_req_i, input, 1: software/debug reset request, rising-edge sensitive.
REQ-007 SHALL have port soft_rst_ack_o, output, 1: one-cycle acknowledge of an accepted soft request.
REQ-008 SHALL have port rst_periph_n_o, output, 1: peripheral reset, active-low.
REQ-009 SHALL have port rst_core_n_o, output, 1: CPU core reset, active-low.
REQ-010 SHALL have port rst_done_o, output, 1: high when the sequence is complete (state RUN).
REQ-011 SHALL have port rst_cause_soft_o, output, 1: sticky flag; 1 means the last reset was a soft reset.

Function
REQ-012 SHALL synchronize rst_sys_n through SYNC_STAGES flops: asynchronous assert, synchronous deassert; the output is rst_sync_n.
REQ-013 SHALL implement FSM states HOLD, PERIPH, RUN, SOFT, all registered.
REQ-014 HOLD: counter increments each cycle while rst_sync_n=1; when counter reaches STRETCH_CYCLES-1, go to PERIPH and clear the counter.
REQ-015 PERIPH: counter increments; at STAGE_GAP-1, go to RUN and clear the counter.
REQ-016 rst_periph_n_o SHALL be 1 exactly in PERIPH and RUN; rst_core_n_o and rst_done_o SHALL be 1 exactly in RUN; all three SHALL be driven from flops.
REQ-017 Release timing: rst_periph_n_o rises STRETCH_CYCLES cycles after the first cycle rst_sync_n=1; rst_core_n_o rises STAGE_GAP cycles after that.
REQ-018 SHALL register soft_rst_req_i once and detect a rising edge as (req & ~req_q); a request held high SHALL trigger exactly one reset.
REQ-019 A rising edge in RUN: next cycle go to SOFT; rst_core_n_o and rst_periph_n_o low; soft_rst_ack_o=1 for that one cycle; rst_cause_soft_o set to 1.
REQ-020 SOFT SHALL last one cycle, then go to HOLD with the counter cleared; the normal stretch sequence follows.
REQ-021 Rising edges outside RUN SHALL be dropped with no ack and no state change.
REQ-022 Counter width SHALL be clog2(max(STRETCH_CYCLES, STAGE_GAP)+1); it SHALL never wrap, because it is cleared on every state exit.
REQ-023 rst_sys_n asserted in any state, including mid-sequence or in SOFT, SHALL force HOLD asynchronously: counter=0, all resets low, ack=0.
REQ-024 rst_sys_n low together with a soft edge: the hard reset wins and rst_cause_soft_o=0.

Reset
REQ-025 On rst_sys_n=0, asynchronously: state=HOLD, counter=0, synchronizer flops=0, req_q=0.
REQ-026 On rst_sys_n=0, asynchronously: rst_periph_n_o=0, rst_core_n_o=0, rst_done_o=0, soft_rst_ack_o=0, rst_cause_soft_o=0.
REQ-027 rst_cause_soft_o SHALL be cleared only by rst_sys_n.

Structure
REQ-028 Package rst_seq_pkg SHALL hold the rst_seq_state_e enum (HOLD, PERIPH, RUN, SOFT) and the default parameter constants.
REQ-029 Sub-module rst_sync SHALL be the N-stage async-assert/sync-deassert synchronizer, instantiated once.
REQ-030 An elaboration-time check SHALL flag illegal parameter values.

Verification (SYNC_STAGES=2, STRETCH_CYCLES=8, STAGE_GAP=4)
REQ-031 Power-up: release rst_sys_n at cycle 0 -> rst_sync_n=1 by cycle 2, periph_n=1 at cycle 10, core_n=1 and done=1 at cycle 14, cause_soft=0.
REQ-032 Soft reset: one-cycle req pulse in RUN -> ack=1 for one cycle, both resets low next cycle, periph_n high 9 cycles later, core_n 4 cycles after that, cause_soft=1.
REQ-033 Held request: req high for 50 cycles from RUN -> exactly one ack, one sequence, then RUN stays stable.
REQ-034 Dropped request: req edge during HOLD at counter=3 -> no ack, release timing unchanged from REQ-031.
REQ-035 Mid-sequence hard reset: rst_sys_n low during PERIPH -> all outputs low in the same cycle (async); after release, full sequence restarts from counter=0.
REQ-036 Glitch: rst_sys_n low for under one cycle in RUN -> outputs drop immediately; full 8+4 sequence replays; cause_soft cleared.
